// File: rtl/sccomp_trace.sv
// Retired-instruction trace buffer: captures 128-bit {pc, inst, aluout, memout}
// records into a small FIFO and streams each one out as 16 bytes, MSB first,
// over a valid/ready byte interface. Records arriving while full are counted.
module sccomp_trace #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 4
) (
  input  logic          clock,
  input  logic          resetn,    // active-high despite the name
  input  logic          cap_en,
  input  logic [31:0]   pc,
  input  logic [31:0]   inst,
  input  logic [31:0]   aluout,
  input  logic [31:0]   memout,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [15:0]   drop_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [15:0]   drop_q;
  state_e        state_q;
  logic [3:0]    idx_q;
  logic [127:0]  shreg_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;

  logic          push, drop, xfer, last_xfer, pop;
  logic [127:0]  head;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign drop_cnt = drop_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign head     = mem[rd_ptr_q];

  // Push and pop decisions use the registered full/empty, so a pop never frees a slot
  // for a push at the same edge.
  always_comb begin
    push      = cap_en & ~full;
    drop      = cap_en & full;
    xfer      = (state_q == StSend) & tx_ready;
    last_xfer = xfer & (idx_q == 4'd15);
    pop       = ~empty & ((state_q == StIdle) | last_xfer);
  end

  // Record storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= {pc, inst, aluout, memout};
  end

  // FIFO pointers, occupancy and overflow counter.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  // Byte transmitter FSM with registered tx_valid/tx_data; loads the next record on
  // the final byte when one is waiting so consecutive records stream without a gap.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      shreg_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pop) begin
            shreg_q    <= head;
            tx_data_q  <= head[127:120];
            idx_q      <= '0;
            tx_valid_q <= 1'b1;
            state_q    <= StSend;
          end
        end
        StSend: begin
          if (last_xfer) begin
            if (pop) begin
              shreg_q   <= head;
              tx_data_q <= head[127:120];
              idx_q     <= '0;
            end else begin
              idx_q      <= '0;
              tx_valid_q <= 1'b0;
              state_q    <= StIdle;
            end
          end else if (xfer) begin
            shreg_q   <= {shreg_q[119:0], 8'h00};
            tx_data_q <= shreg_q[119:112];
            idx_q     <= idx_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sccomp_trace.sv
// Bench for sccomp_trace: a queue-based reference model of the trace buffer runs
// alongside the DUT, and each scenario task compares DUT outputs against it.
module tb_sccomp_trace;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b1;
  logic          cap_en = 1'b0;
  logic [31:0]   pc = '0, inst = '0, aluout = '0, memout = '0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          full, empty;
  logic [CW-1:0] count;
  logic [15:0]   drop_cnt;

  int nchecks = 0;
  int nerrors = 0;

  // Reference model state
  logic [127:0] mq[$];
  logic [127:0] mcur;
  int           midx;
  bit           msend;
  int           mdrop;
  logic [7:0]   mlast;
  logic [7:0]   exp_q[$];
  logic [7:0]   got_q[$];

  sccomp_trace #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .cap_en   (cap_en),
    .pc       (pc),
    .inst     (inst),
    .aluout   (aluout),
    .memout   (memout),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .drop_cnt (drop_cnt)
  );

  always #5 clock = ~clock;

  // One clock edge: log any DUT byte handshake, advance the model, settle 1 time unit.
  task automatic tick();
    int  pre;
    bit  mfull, mempty;
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    @(posedge clock);
    if (resetn) begin
      mq.delete(); msend = 0; midx = 0; mdrop = 0; mlast = 8'h00;
    end else begin
      pre    = mq.size();
      mfull  = (pre == DEPTH);
      mempty = (pre == 0);
      if (msend) begin
        if (tx_ready) begin
          exp_q.push_back(mcur[127-8*midx -: 8]);
          midx++;
          if (midx == 16) begin
            midx = 0;
            if (!mempty) mcur = mq.pop_front();
            else msend = 0;
          end
        end
      end else if (!mempty) begin
        mcur = mq.pop_front(); midx = 0; msend = 1;
      end
      if (cap_en) begin
        if (!mfull) mq.push_back({pc, inst, aluout, memout});
        else if (mdrop < 65535) mdrop++;
      end
      if (msend) mlast = mcur[127-8*midx -: 8];
    end
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b1; cap_en = 1'b0; tx_ready = 1'b0;
    tick();
    resetn = 1'b0;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic rand_rec();
    pc = $urandom; inst = $urandom; aluout = $urandom; memout = $urandom;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    #2;
    nchecks++; if (tx_valid !== 1'b0) begin nerrors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
    nchecks++; if (tx_data !== 8'h00) begin nerrors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    nchecks++; if (count !== '0) begin nerrors++; $display("FAIL reset_count got %0d exp 0", count); end
    nchecks++; if ({full, empty} !== 2'b01) begin nerrors++; $display("FAIL reset_flags full/empty got %b%b exp 01", full, empty); end
    nchecks++; if (drop_cnt !== 16'h0) begin nerrors++; $display("FAIL reset_drop got %h exp 0", drop_cnt); end
    do_reset();
  endtask

  task automatic test_single(input bit backpressure);
    logic [7:0] exp36 [16];
    logic [7:0] held;
    bit         stalled;
    exp36 = '{8'h00, 8'h40, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05,
              8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    do_reset();
    pc = 32'h00400000; inst = 32'h20080005; aluout = 32'h5; memout = 32'h0;
    cap_en = 1'b1; tx_ready = 1'b1;
    tick();  // first edge after reset release
    cap_en = 1'b0;
    nchecks++; if (count !== CW'(1) || empty !== 1'b0) begin nerrors++; $display("FAIL first_push count got %0d empty %b exp 1/0", count, empty); end
    tick();
    nchecks++; if (tx_valid !== 1'b1) begin nerrors++; $display("FAIL latency_valid got %b exp 1", tx_valid); end
    nchecks++; if (count !== '0) begin nerrors++; $display("FAIL latency_count got %0d exp 0", count); end
    for (int c = 0; c < (backpressure ? 40 : 16); c++) begin
      if (backpressure) tx_ready = c[0] ? 1'b0 : 1'b1;
      stalled = tx_valid && !tx_ready;
      held = tx_data;
      tick();
      if (stalled) begin
        nchecks++; if (tx_data !== held) begin nerrors++; $display("FAIL stall_stable got %h exp %h", tx_data, held); end
      end
      nchecks++; if (tx_valid !== msend || tx_data !== mlast) begin
        nerrors++; $display("FAIL single_model valid/data got %b/%h exp %b/%h", tx_valid, tx_data, msend, mlast);
      end
    end
    nchecks++; if (got_q.size() != 16) begin nerrors++; $display("FAIL single_len got %0d exp 16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      nchecks++; if (got_q[i] !== exp36[i]) begin nerrors++; $display("FAIL single_byte%0d got %h exp %h", i, got_q[i], exp36[i]); end
    end
    nchecks++; if (tx_valid !== 1'b0) begin nerrors++; $display("FAIL single_end_valid got %b exp 0", tx_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    tx_ready = 1'b0; cap_en = 1'b1;
    for (int c = 0; c < 12; c++) begin rand_rec(); tick(); end
    cap_en = 1'b0;
    nchecks++; if (count !== CW'(8) || full !== 1'b1) begin nerrors++; $display("FAIL overflow_count got %0d full %b exp 8/1", count, full); end
    nchecks++; if (drop_cnt !== 16'd3) begin nerrors++; $display("FAIL overflow_drop got %0d exp 3", drop_cnt); end
    nchecks++; if (tx_valid !== 1'b1) begin nerrors++; $display("FAIL overflow_inflight got %b exp 1", tx_valid); end
  endtask

  // Continues from test_overflow: drain 15 bytes, then push on the byte-15 pop edge.
  task automatic test_push_pop_full();
    tx_ready = 1'b1;
    for (int c = 0; c < 15; c++) tick();
    nchecks++; if (count !== CW'(8)) begin nerrors++; $display("FAIL ppf_pre_count got %0d exp 8", count); end
    cap_en = 1'b1; rand_rec();
    tick();
    cap_en = 1'b0; tx_ready = 1'b0;
    nchecks++; if (count !== CW'(7) || full !== 1'b0) begin nerrors++; $display("FAIL ppf_count got %0d full %b exp 7/0", count, full); end
    nchecks++; if (drop_cnt !== 16'd4) begin nerrors++; $display("FAIL ppf_drop got %0d exp 4", drop_cnt); end
    nchecks++; if (tx_valid !== 1'b1) begin nerrors++; $display("FAIL ppf_valid got %b exp 1", tx_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tx_ready = 1'b0; cap_en = 1'b1;
    for (int c = 0; c < 3; c++) begin rand_rec(); tick(); end
    cap_en = 1'b0;
    tx_ready = 1'b1;
    for (int c = 0; c < 48; c++) begin
      nchecks++; if (tx_valid !== 1'b1) begin nerrors++; $display("FAIL b2b_gap cycle %0d got %b exp 1", c, tx_valid); end
      tick();
    end
    nchecks++; if (got_q.size() != 48 || exp_q.size() != 48) begin
      nerrors++; $display("FAIL b2b_len got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < 48 && i < got_q.size() && i < exp_q.size(); i++) begin
      nchecks++; if (got_q[i] !== exp_q[i]) begin nerrors++; $display("FAIL b2b_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    nchecks++; if (empty !== 1'b1 || tx_valid !== 1'b0) begin nerrors++; $display("FAIL b2b_end empty/valid got %b/%b exp 1/0", empty, tx_valid); end
  endtask

  task automatic test_reset_midrecord();
    do_reset();
    tx_ready = 1'b0; cap_en = 1'b1;
    for (int c = 0; c < 3; c++) begin rand_rec(); tick(); end
    cap_en = 1'b0; tx_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    nchecks++; if (count !== CW'(2)) begin nerrors++; $display("FAIL mid_pre_count got %0d exp 2", count); end
    #2 resetn = 1'b1;
    #1;
    nchecks++; if (tx_valid !== 1'b0 || count !== '0 || empty !== 1'b1) begin
      nerrors++; $display("FAIL mid_reset valid/count/empty got %b/%0d/%b exp 0/0/1", tx_valid, count, empty);
    end
    @(negedge clock);
    tick();
    resetn = 1'b0;
    got_q.delete();
    for (int c = 0; c < 20; c++) tick();
    nchecks++; if (got_q.size() != 0) begin nerrors++; $display("FAIL mid_no_bytes got %0d exp 0", got_q.size()); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      cap_en   = ($urandom_range(0, 99) < 35);
      tx_ready = ($urandom_range(0, 99) < 60);
      rand_rec();
      tick();
      nchecks++; if (tx_valid !== msend || tx_data !== mlast) begin
        nerrors++; $display("FAIL rand_tx c%0d valid/data got %b/%h exp %b/%h", c, tx_valid, tx_data, msend, mlast);
      end
      nchecks++; if (count !== CW'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin
        nerrors++; $display("FAIL rand_fifo c%0d count/full/empty got %0d/%b/%b exp %0d", c, count, full, empty, mq.size());
      end
      nchecks++; if (drop_cnt !== 16'(mdrop)) begin nerrors++; $display("FAIL rand_drop c%0d got %0d exp %0d", c, drop_cnt, mdrop); end
    end
    cap_en = 1'b0; tx_ready = 1'b1;
    for (int c = 0; c < 200; c++) tick();
    nchecks++; if (got_q.size() != exp_q.size()) begin nerrors++; $display("FAIL rand_stream_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        nchecks++; nerrors++; $display("FAIL rand_stream byte%0d got %h exp %h", i, got_q[i], exp_q[i]);
        break;
      end
    end
  endtask

  initial begin
    mq.delete(); msend = 0; midx = 0; mdrop = 0; mlast = 8'h00; mcur = '0;
    @(negedge clock);
    test_reset();
    test_single(1'b0);
    test_single(1'b1);
    test_overflow();
    test_push_pop_full();
    test_back_to_back();
    test_reset_midrecord();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
